// File: rtl/cpu_pkg.sv
// Shared types and requester indices for the cpu memory-side arbiters.
package cpu_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_ACK} arb_state_t;

  localparam int unsigned REQ_FETCH   = 0;
  localparam int unsigned REQ_DCACHE  = 1;
  localparam int unsigned REQ_EXECUTE = 2;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational grant picker: round-robin after last_grant, or highest index wins.
module rr_picker #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  input  logic             rr_en,
  output logic [GW-1:0]    grant,
  output logic             any_req
);

  int unsigned      idx;
  logic [N_REQ-1:0] sh;
  logic             found;

  always_comb begin
    grant   = '0;
    any_req = |req;
    idx     = 0;
    sh      = '0;
    found   = 1'b0;
    if (rr_en) begin
      // Walk last_grant+1, +2, ... wrapping; the first hit is the nearest successor.
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        idx = (32'(last_grant) + k) % N_REQ;
        sh  = req >> idx;
        if (!found && sh[0]) begin
          grant = GW'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        sh = req >> k;
        if (sh[0]) grant = GW'(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Registered one-access-at-a-time bus controller for the cpu memory requesters,
// with ready-based wait states and a timeout/bus-error completion.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned RR_EN   = 1,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      m_req,
  input  logic [N_REQ-1:0][31:0] m_addr,
  input  logic [N_REQ-1:0][31:0] m_wdata,
  input  logic [N_REQ-1:0]      m_we,
  output logic [N_REQ-1:0]      m_ack,
  output logic [31:0]           m_rdata,
  output logic                  m_err,
  output logic [31:0]           addr,
  output logic [31:0]           data_out,
  output logic                  mem_we,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  input  logic [31:0]           data_in
);

  localparam int unsigned      GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [GW-1:0]    LAST_RST = GW'(N_REQ - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  arb_state_t      state;
  // Holds the current owner while busy and doubles as last_grant for the picker.
  logic [GW-1:0]   grant;
  logic [TO_W-1:0] to_cnt;
  logic            dropped;
  logic [GW-1:0]   pick;
  logic            any_req;
  logic            timed_out;

  rr_picker #(.N_REQ(N_REQ), .GW(GW)) u_picker (
    .req        (m_req),
    .last_grant (grant),
    .rr_en      (RR_EN != 0),
    .grant      (pick),
    .any_req    (any_req)
  );

  assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      grant     <= LAST_RST;
      to_cnt    <= '0;
      dropped   <= 1'b0;
      m_ack     <= '0;
      m_rdata   <= '0;
      m_err     <= 1'b0;
      addr      <= '0;
      data_out  <= '0;
      mem_we    <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant     <= pick;
            addr      <= m_addr[pick];
            data_out  <= m_wdata[pick];
            mem_we    <= m_we[pick];
            mem_valid <= 1'b1;
            to_cnt    <= '0;
            dropped   <= 1'b0;
            state     <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
          if (mem_ready || timed_out) begin
            // Ready takes precedence over a coincident timeout.
            m_rdata   <= (mem_ready && !mem_we) ? data_in : '0;
            m_err     <= !mem_ready;
            if (m_req[grant] && !dropped) m_ack[grant] <= 1'b1;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            state     <= ARB_ACK;
          end else if (!m_req[grant]) begin
            dropped <= 1'b1;
          end
        end
        ARB_ACK: begin
          m_ack   <= '0;
          m_rdata <= '0;
          m_err   <= 1'b0;
          state   <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, corner-case sequences and a randomized run against a reference model.
module tb_mem_arbiter;
  import cpu_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       m_req, m_we;
  logic [2:0][31:0] m_addr, m_wdata;
  logic [31:0]      data_in;
  logic             rdy_ab, rdy_c;

  logic [2:0]  ack_a, ack_b, ack_c;
  logic [31:0] rdata_a, rdata_b, rdata_c, addr_a, addr_b, addr_c, dout_a, dout_b, dout_c;
  logic        err_a, err_b, err_c, we_a, we_b, we_c, valid_a, valid_b, valid_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N_REQ(3), .RR_EN(1), .TIMEOUT(64), .TO_W(7)) dut_a (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_ack(ack_a), .m_rdata(rdata_a), .m_err(err_a), .addr(addr_a), .data_out(dout_a),
    .mem_we(we_a), .mem_valid(valid_a), .mem_ready(rdy_ab), .data_in(data_in));

  mem_arbiter #(.N_REQ(3), .RR_EN(0), .TIMEOUT(0), .TO_W(7)) dut_b (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_ack(ack_b), .m_rdata(rdata_b), .m_err(err_b), .addr(addr_b), .data_out(dout_b),
    .mem_we(we_b), .mem_valid(valid_b), .mem_ready(rdy_ab), .data_in(data_in));

  mem_arbiter #(.N_REQ(3), .RR_EN(1), .TIMEOUT(4), .TO_W(3)) dut_c (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_ack(ack_c), .m_rdata(rdata_c), .m_err(err_c), .addr(addr_c), .data_out(dout_c),
    .mem_we(we_c), .mem_valid(valid_c), .mem_ready(rdy_c), .data_in(data_in));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [2:0] a);
    case (a)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_req = '0;
    rdy_ab = 1'b0;
    rdy_c = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic        we;
    logic [31:0] din;
    int          waits;
    int          ga;
    int          gb;
  } vec_t;

  vec_t vt[8];
  int   exp_rr[4];
  int   qa[$];
  int   qb[$];

  // reference model state for the randomized run (round-robin, TIMEOUT=64)
  int          ph, g, last, cnt;
  bit          drop;
  logic [2:0]  pend, e_ack;
  logic [31:0] e_addr, e_dout, e_rdata;
  logic        e_we, e_valid, e_err;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{req: 3'b001, we: 1'b0, din: 32'hCAFEF00D, waits: 0, ga: 0, gb: 0};
    vt[1] = '{req: 3'b111, we: 1'b1, din: 32'h11111111, waits: 1, ga: 1, gb: 2};
    vt[2] = '{req: 3'b111, we: 1'b0, din: 32'h22222222, waits: 5, ga: 2, gb: 2};
    vt[3] = '{req: 3'b111, we: 1'b0, din: 32'h33333333, waits: 2, ga: 0, gb: 2};
    vt[4] = '{req: 3'b101, we: 1'b1, din: 32'h44444444, waits: 0, ga: 2, gb: 2};
    vt[5] = '{req: 3'b011, we: 1'b0, din: 32'h55555555, waits: 3, ga: 0, gb: 1};
    vt[6] = '{req: 3'b110, we: 1'b0, din: 32'h66666666, waits: 0, ga: 1, gb: 2};
    vt[7] = '{req: 3'b010, we: 1'b1, din: 32'h77777777, waits: 1, ga: 1, gb: 1};

    m_we = '0; m_addr = '0; m_wdata = '0; data_in = '0;
    do_reset();
    chk("reset valid_a", valid_a, 0);
    chk("reset ack_a", ack_a, 0);
    chk("reset addr_a", addr_a, 0);
    chk("reset dout_a", dout_a, 0);
    chk("reset we_a", we_a, 0);
    chk("reset rdata_a", rdata_a, 0);
    chk("reset err_a", err_a, 0);
    chk("reset valid_b", valid_b, 0);

    // vector table: single accesses through the round-robin and fixed-priority instances
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 3; i++) begin
        m_addr[i]  = 32'h100 + i * 32'h1000 + v * 32'h10;
        m_wdata[i] = 32'hD000_0000 + i * 32'h100 + v;
      end
      m_we  = {3{vt[v].we}};
      m_req = vt[v].req;
      rdy_ab = 1'b0;
      tick();
      chk($sformatf("v%0d valid_a", v), valid_a, 1);
      chk($sformatf("v%0d addr_a", v), addr_a, m_addr[vt[v].ga]);
      chk($sformatf("v%0d dout_a", v), dout_a, m_wdata[vt[v].ga]);
      chk($sformatf("v%0d we_a", v), we_a, vt[v].we);
      chk($sformatf("v%0d addr_b", v), addr_b, m_addr[vt[v].gb]);
      for (int k = 0; k < vt[v].waits; k++) begin
        tick();
        chk($sformatf("v%0d wait valid_a", v), valid_a, 1);
        chk($sformatf("v%0d wait addr_a", v), addr_a, m_addr[vt[v].ga]);
        chk($sformatf("v%0d wait ack_a", v), ack_a, 0);
      end
      rdy_ab = 1'b1;
      data_in = vt[v].din;
      tick();
      rdy_ab = 1'b0;
      data_in = $urandom;
      chk($sformatf("v%0d ack_a", v), ack_a, 32'(1 << vt[v].ga));
      chk($sformatf("v%0d rdata_a", v), rdata_a, vt[v].we ? 32'h0 : vt[v].din);
      chk($sformatf("v%0d err_a", v), err_a, 0);
      chk($sformatf("v%0d valid_a off", v), valid_a, 0);
      chk($sformatf("v%0d ack_b", v), ack_b, 32'(1 << vt[v].gb));
      chk($sformatf("v%0d rdata_b", v), rdata_b, vt[v].we ? 32'h0 : vt[v].din);
      m_req = '0;
      tick();
      chk($sformatf("v%0d ack_a clear", v), ack_a, 0);
      chk($sformatf("v%0d rdata_a clear", v), rdata_a, 0);
    end

    // contention: all three held, memory always ready
    do_reset();
    exp_rr = '{REQ_FETCH, REQ_DCACHE, REQ_EXECUTE, REQ_FETCH};
    m_we = '0;
    m_req = 3'b111;
    rdy_ab = 1'b1;
    for (int c = 0; c < 30 && (qa.size() < 4 || qb.size() < 4); c++) begin
      tick();
      if (ack_a != 0) qa.push_back(oh2i(ack_a));
      if (ack_b != 0) qb.push_back(oh2i(ack_b));
    end
    rdy_ab = 1'b0;
    m_req = '0;
    chk("rr ack count", qa.size(), 4);
    chk("fixed ack count", qb.size(), 4);
    for (int i = 0; i < qa.size() && i < 4; i++) chk($sformatf("rr grant %0d", i), qa[i], exp_rr[i]);
    for (int i = 0; i < qb.size() && i < 4; i++) chk($sformatf("fixed grant %0d", i), qb[i], REQ_EXECUTE);

    // abandoned request: fetch drops its request mid-access
    do_reset();
    m_req = 3'b001;
    tick();
    chk("abandon valid_a", valid_a, 1);
    m_req = '0;
    tick();
    rdy_ab = 1'b1;
    tick();
    rdy_ab = 1'b0;
    chk("abandon ack_a", ack_a, 0);
    chk("abandon valid_a off", valid_a, 0);

    // timeout on the TIMEOUT=4 instance, then ready coinciding with the last count
    do_reset();
    m_we = '0;
    m_req = 3'b010;
    data_in = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("to access %0d valid_c", k), valid_c, 1);
      chk($sformatf("to access %0d ack_c", k), ack_c, 0);
    end
    tick();
    chk("to ack_c", ack_c, 3'b010);
    chk("to err_c", err_c, 1);
    chk("to rdata_c", rdata_c, 0);
    chk("to valid_c off", valid_c, 0);
    m_req = '0;
    tick();
    chk("to ack_c clear", ack_c, 0);
    chk("to err_c clear", err_c, 0);
    m_req = 3'b001;
    tick();
    chk("to rebus valid_c", valid_c, 1);
    chk("to rebus addr_c", addr_c, m_addr[0]);
    for (int k = 0; k < 3; k++) tick();
    rdy_c = 1'b1;
    data_in = 32'h5A5A1234;
    tick();
    rdy_c = 1'b0;
    chk("tie ack_c", ack_c, 3'b001);
    chk("tie err_c", err_c, 0);
    chk("tie rdata_c", rdata_c, 32'h5A5A1234);
    m_req = '0;
    tick();

    // reset during a write access
    do_reset();
    m_addr[1] = 32'h200;
    m_wdata[1] = 32'h0000ABCD;
    m_we = 3'b010;
    m_req = 3'b010;
    tick();
    chk("rst addr_a", addr_a, 32'h200);
    chk("rst we_a", we_a, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst valid_a", valid_a, 0);
    chk("rst ack_a", ack_a, 0);
    chk("rst we_a off", we_a, 0);
    m_we = '0;
    m_req = 3'b111;
    tick();
    chk("rst first prio", addr_a, m_addr[0]);

    // randomized traffic against the reference model
    do_reset();
    ph = 0; last = 2; g = 0; cnt = 0; drop = 0; pend = '0;
    e_valid = 0; e_we = 0; e_addr = 0; e_dout = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          m_addr[i] = $urandom;
          m_wdata[i] = $urandom;
          m_we[i] = 1'($urandom_range(0, 1));
        end
      end
      m_req = pend;
      rdy_ab = ($urandom_range(0, 9) < 4);
      data_in = $urandom;
      @(posedge clk);
      e_ack = '0; e_err = 0; e_rdata = '0;
      if (ph == 0) begin
        if (m_req != 0) begin
          for (int k = 3; k >= 1; k--)
            if (m_req[(last + k) % 3]) g = (last + k) % 3;
          last = g; ph = 1; cnt = 0; drop = 0;
          e_addr = m_addr[g]; e_dout = m_wdata[g]; e_we = m_we[g]; e_valid = 1;
        end
      end else if (ph == 1) begin
        if (rdy_ab || cnt == 63) begin
          e_err = !rdy_ab;
          e_rdata = (rdy_ab && !e_we) ? data_in : 32'h0;
          e_ack = (m_req[g] && !drop) ? 3'(1 << g) : 3'b000;
          e_valid = 0; e_we = 0; ph = 2;
        end else begin
          if (!m_req[g]) drop = 1;
          cnt++;
        end
      end else begin
        ph = 0;
      end
      #1;
      chk("rnd valid", valid_a, e_valid);
      chk("rnd we", we_a, e_we);
      chk("rnd ack", ack_a, e_ack);
      chk("rnd err", err_a, e_err);
      chk("rnd rdata", rdata_a, e_rdata);
      if (e_valid) begin
        chk("rnd addr", addr_a, e_addr);
        chk("rnd dout", dout_a, e_dout);
      end
      pend = pend & ~e_ack;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
